// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, external interrupts and mret,
// owns mstatus(MIE/MPIE)/mtvec/mepc/mcause, and issues a one-cycle redirect/flush.
//
// state  | meaning
// IDLE   | normal execution, decoding events and accepting CSR writes
// SAVE   | trap taken, CSRs already saved, PC held
// VECTOR | redirect/flush to the trap vector
// RET    | redirect/flush to mepc after mret
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic [7:0]  scause_i,
    input  logic        mret_i,
    input  logic        ext_irq_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [31:0] IRQ_CAUSE    = 32'h8000_000B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        idle;
    logic        take_ret;
    logic        take_exc;
    logic        take_irq;
    logic        take_event;
    logic        csr_wr_en;

    // mret outranks everything because the decoder also flags it as illegal.
    assign idle       = (state_q == IDLE);
    assign take_ret   = idle && instr_valid_i && mret_i;
    assign take_exc   = idle && instr_valid_i && !mret_i && (scause_i != 8'h00);
    assign take_irq   = idle && instr_valid_i && !mret_i && (scause_i == 8'h00)
                        && ext_irq_i && mie_q;
    assign take_event = take_ret || take_exc || take_irq;
    assign csr_wr_en  = idle && csr_we_i && !take_event;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= {MTVEC_RESET[31:2], 2'b00};
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_ret) begin
                    state_d = RET;
                end else if (take_exc || take_irq) begin
                    state_d = SAVE;
                end
            end
            SAVE:    state_d = VECTOR;
            VECTOR:  state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o       = take_event || !idle;
        busy_o        = !idle;
        redirect_o    = 1'b0;
        flush_o       = 1'b0;
        redirect_pc_o = 32'h0;
        case (state_q)
            VECTOR: begin
                redirect_o    = 1'b1;
                flush_o       = 1'b1;
                redirect_pc_o = {mtvec_q[31:2], 2'b00};
            end
            RET: begin
                redirect_o    = 1'b1;
                flush_o       = 1'b1;
                redirect_pc_o = mepc_q;
            end
            default: ;
        endcase
    end

    // CSR next-state: sequence updates win over software writes in the same cycle.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (take_ret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (take_exc || take_irq) begin
            mepc_d   = {pc_i[31:2], 2'b00};
            mcause_d = take_exc ? {24'h0, scause_i} : IRQ_CAUSE;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (csr_wr_en) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mie_d  = csr_wdata_i[3];
                    mpie_d = csr_wdata_i[7];
                end
                ADDR_MTVEC:  mtvec_d  = {csr_wdata_i[31:2], 2'b00};
                ADDR_MEPC:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
                ADDR_MCAUSE: mcause_d = csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata_o = 32'h0;
        case (csr_addr_i)
            ADDR_MSTATUS: csr_rdata_o = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            ADDR_MTVEC:   csr_rdata_o = mtvec_q;
            ADDR_MEPC:    csr_rdata_o = mepc_q;
            ADDR_MCAUSE:  csr_rdata_o = mcause_q;
            default: ;
        endcase
    end

endmodule
